// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants and micro-op kinds for the encoder and the core's decoder.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [3:0] {
        KIND_ADD  = 4'd0,
        KIND_SUB  = 4'd1,
        KIND_AND  = 4'd2,
        KIND_OR   = 4'd3,
        KIND_SLT  = 4'd4,
        KIND_ADDI = 4'd5,
        KIND_LW   = 4'd6,
        KIND_SW   = 4'd7,
        KIND_BEQ  = 4'd8,
        KIND_BNE  = 4'd9
    } req_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } enc_state_e;

endpackage

// File: rtl/instr_packer.sv
// Combinational packing of one micro-op into an RV32I word, flagging kinds or immediates it cannot express.
module instr_packer
    import rv_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic imm12_fits;
    logic imm_even;

    // 12-bit immediates need the 13-bit value to sign-extend from bit 11; branch offsets must be halfword aligned.
    assign imm12_fits = (imm[12] == imm[11]);
    assign imm_even   = ~imm[0];

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            KIND_ADD:  word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OP_R};
            KIND_SUB:  word = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OP_R};
            KIND_AND:  word = {F7_BASE, rs2, rs1, F3_AND,     rd, OP_R};
            KIND_OR:   word = {F7_BASE, rs2, rs1, F3_OR,      rd, OP_R};
            KIND_SLT:  word = {F7_BASE, rs2, rs1, F3_SLT,     rd, OP_R};
            KIND_ADDI: begin
                word    = {imm[11:0], rs1, F3_ADD_SUB, rd, OP_I};
                illegal = ~imm12_fits;
            end
            KIND_LW: begin
                word    = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
                illegal = ~imm12_fits;
            end
            KIND_SW: begin
                word    = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
                illegal = ~imm12_fits;
            end
            KIND_BEQ: begin
                word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
                illegal = ~imm_even;
            end
            KIND_BNE: begin
                word    = {imm[12], imm[10:5], rs2, rs1, F3_BNE, imm[4:1], imm[11], OP_BRANCH};
                illegal = ~imm_even;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/prog_encoder.sv
// Session-based micro-op encoder that streams RV32I words into instruction memory at consecutive addresses.
module prog_encoder
    import rv_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  finish,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_kind,
    input  logic [4:0]            req_rd,
    input  logic [4:0]            req_rs1,
    input  logic [4:0]            req_rs2,
    input  logic [12:0]           req_imm,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    enc_state_e            state;
    enc_state_e            state_next;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [31:0]           packed_word;
    logic                  packed_illegal;
    logic                  accept;
    logic                  full;
    logic                  open_session;

    instr_packer u_packer (
        .kind    (req_kind),
        .rd      (req_rd),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .imm     (req_imm),
        .word    (packed_word),
        .illegal (packed_illegal)
    );

    assign busy         = (state == ST_LOAD);
    assign full         = (count == DEPTH_CNT);
    assign req_ready    = busy && !finish && (count < DEPTH_CNT);
    assign accept       = req_valid && req_ready;
    assign open_session = start && (state != ST_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)  state_next = ST_LOAD;
            ST_LOAD: if (finish) state_next = ST_DONE;
            ST_DONE: if (start)  state_next = ST_LOAD;
            default:             state_next = ST_IDLE;
        endcase
    end

    // Count and pointer advance at accept time so req_ready already sees a word that is still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            ptr        <= '0;
            count      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (open_session) begin
                ptr      <= '0;
                count    <= '0;
                done     <= 1'b0;
                err      <= 1'b0;
                overflow <= 1'b0;
            end else begin
                if (accept) begin
                    if (packed_illegal) begin
                        err <= 1'b1;
                    end else begin
                        imem_we    <= 1'b1;
                        imem_waddr <= ptr;
                        imem_wdata <= packed_word;
                        ptr        <= ptr + 1'b1;
                        count      <= count + 1'b1;
                    end
                end
                if (busy && req_valid && full) overflow <= 1'b1;
                if (busy && finish)            done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_encoder.sv
// Randomized and directed bench for prog_encoder against a behavioural session model.
module tb_prog_encoder;

    localparam int AW    = 3;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          finish = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_kind = '0;
    logic [4:0]    req_rd = '0;
    logic [4:0]    req_rs1 = '0;
    logic [4:0]    req_rs2 = '0;
    logic [12:0]   req_imm = '0;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          err;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    bit          m_open, m_done, m_err, m_ovf, m_we;
    int          m_count;
    logic [31:0] m_addr;
    logic [31:0] m_data;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];

    prog_encoder #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .finish     (finish),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Assembles the word field by field from the ISA layout and judges legality from the numeric immediate.
    function automatic logic [31:0] encode(input int kind, input int rd, input int rs1, input int rs2,
                                           input int immv, output bit bad);
        logic [31:0] regs_r;
        logic [31:0] w;
        bad    = 1'b0;
        w      = '0;
        regs_r = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7);
        case (kind)
            0: w = regs_r | 32'h33;
            1: w = regs_r | (32'd32 << 25) | 32'h33;
            2: w = regs_r | (32'd7 << 12) | 32'h33;
            3: w = regs_r | (32'd6 << 12) | 32'h33;
            4: w = regs_r | (32'd2 << 12) | 32'h33;
            5, 6: begin
                bad = (immv < -2048) || (immv > 2047);
                w = (32'(immv & 'hfff) << 20) | (32'(rs1) << 15) | (32'(rd) << 7)
                    | ((kind == 5) ? 32'h13 : ((32'd2 << 12) | 32'h03));
            end
            7: begin
                bad = (immv < -2048) || (immv > 2047);
                w = (32'((immv >>> 5) & 'h7f) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                    | (32'd2 << 12) | (32'(immv & 'h1f) << 7) | 32'h23;
            end
            8, 9: begin
                bad = (immv % 2) != 0;
                w = (32'((immv >>> 12) & 1) << 31) | (32'((immv >>> 5) & 'h3f) << 25)
                    | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(kind - 8) << 12)
                    | (32'((immv >>> 1) & 'hf) << 8) | (32'((immv >>> 11) & 1) << 7) | 32'h63;
            end
            default: bad = 1'b1;
        endcase
        return w;
    endfunction

    // Session model: a session is open or not, holds a word count, and produces at most one write per accepted request.
    always @(posedge clk or negedge rst_n) begin : model
        bit          rdy;
        bit          bad;
        int          pre_count;
        logic [31:0] w;
        if (!rst_n) begin
            m_open = 0; m_done = 0; m_err = 0; m_ovf = 0; m_we = 0;
            m_count = 0; m_addr = '0; m_data = '0;
        end else begin
            rdy       = m_open && !finish && (m_count < DEPTH);
            pre_count = m_count;
            m_we      = 0;
            if (!m_open && start) begin
                m_open = 1; m_count = 0; m_err = 0; m_ovf = 0; m_done = 0;
            end else if (m_open) begin
                if (req_valid && rdy) begin
                    w = encode(int'(req_kind), int'(req_rd), int'(req_rs1), int'(req_rs2),
                               int'($signed(req_imm)), bad);
                    if (bad) m_err = 1;
                    else begin
                        m_we    = 1;
                        m_addr  = 32'(m_count % (1 << AW));
                        m_data  = w;
                        m_count = m_count + 1;
                    end
                end
                if (req_valid && pre_count == DEPTH) m_ovf = 1;
                if (finish) begin
                    m_open = 0;
                    m_done = 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cycle, actual, expected);
        end
    endtask

    always @(negedge clk) begin : compare
        bit exp_ready;
        exp_ready = m_open && !finish && (m_count < DEPTH);
        checkOutput("imem_we", 32'(imem_we), 32'(m_we));
        if (m_we) begin
            checkOutput("imem_waddr", 32'(imem_waddr), m_addr);
            checkOutput("imem_wdata", imem_wdata, m_data);
        end
        checkOutput("count", 32'(count), 32'(m_count));
        checkOutput("busy", 32'(busy), 32'(m_open));
        checkOutput("done", 32'(done), 32'(m_done));
        checkOutput("err", 32'(err), 32'(m_err));
        checkOutput("overflow", 32'(overflow), 32'(m_ovf));
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    end

    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            log_addr.push_back(32'(imem_waddr));
            log_data.push_back(imem_wdata);
            log_cyc.push_back(cycle);
        end
    end

    // Holds the request until it is accepted or the wait bound runs out; leaves req_valid high on return.
    task automatic applyStimulus(input int kind, input int rd, input int rs1, input int rs2,
                                 input int immv, input bit expect_accept);
        bit r;
        bit accepted;
        accepted  = 0;
        req_valid = 1'b1;
        req_kind  = 4'(kind);
        req_rd    = 5'(rd);
        req_rs1   = 5'(rs1);
        req_rs2   = 5'(rs2);
        req_imm   = 13'(immv);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r = req_ready;
            @(posedge clk);
            #1;
            if (r) begin
                accepted = 1;
                break;
            end
        end
        checkOutput("accept", 32'(accepted), 32'(expect_accept));
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulseFinish();
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
    endtask

    task automatic settle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkLog(input string name, input int idx, input int addr, input logic [31:0] data);
        if (idx >= log_data.size()) begin
            checkOutput({name, "_present"}, 32'(log_data.size()), 32'(idx + 1));
        end else begin
            checkOutput({name, "_addr"}, log_addr[idx], 32'(addr));
            checkOutput({name, "_data"}, log_data[idx], data);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          base;
        logic [31:0] stream_words[4];
        int          immv;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset while a write is pending in an open session
        pulseStart();
        req_valid = 1'b1; req_kind = 4'd5; req_rd = 5'd1; req_rs1 = '0; req_imm = 13'd5;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_we", 32'(imem_we), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 1'b0;
        pulseStart();
        @(negedge clk);
        checkOutput("start_count", 32'(count), 32'd0);
        checkOutput("start_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;

        // ADDI x1,x0,5
        applyStimulus(5, 1, 0, 0, 5, 1);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("addi_we", 32'(imem_we), 32'd1);
        checkOutput("addi_addr", 32'(imem_waddr), 32'd0);
        checkOutput("addi_data", imem_wdata, 32'h00500093);
        checkOutput("addi_count", 32'(count), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back stream of R, I and S formats
        pulseFinish();
        pulseStart();
        base = log_data.size();
        applyStimulus(0, 3, 1, 2, 0, 1);
        applyStimulus(1, 3, 1, 2, 0, 1);
        applyStimulus(6, 5, 2, 0, 8, 1);
        applyStimulus(7, 0, 2, 5, 12, 1);
        settle(2);
        stream_words = '{32'h002081B3, 32'h402081B3, 32'h00812283, 32'h00512623};
        for (int i = 0; i < 4; i++) begin
            checkLog("stream", base + i, i, stream_words[i]);
            if (base + i < log_cyc.size())
                checkOutput("stream_cycle", 32'(log_cyc[base + i] - log_cyc[base]), 32'(i));
        end

        // Branch encodings
        pulseFinish();
        pulseStart();
        base = log_data.size();
        applyStimulus(9, 0, 1, 2, -8, 1);
        applyStimulus(8, 0, 0, 0, 0, 1);
        settle(2);
        checkLog("bne", base, 0, 32'hFE209CE3);
        checkLog("beq", base + 1, 1, 32'h00000063);

        // Illegal requests are consumed without a write
        pulseFinish();
        pulseStart();
        base = log_data.size();
        applyStimulus(5, 1, 0, 0, 2048, 1);
        applyStimulus(8, 0, 1, 2, 3, 1);
        applyStimulus(12, 1, 1, 1, 0, 1);
        settle(2);
        checkOutput("illegal_err", 32'(err), 32'd1);
        checkOutput("illegal_count", 32'(count), 32'd0);
        checkOutput("illegal_nowrite", 32'(log_data.size() - base), 32'd0);
        applyStimulus(5, 2, 0, 0, -1, 1);
        settle(2);
        checkLog("after_err", base, 0, 32'hFFF00113);

        // Fill to DEPTH then one extra request
        pulseFinish();
        pulseStart();
        for (int i = 0; i < DEPTH; i++) applyStimulus(5, i + 1, 0, 0, i, 1);
        applyStimulus(5, 9, 0, 0, 9, 0);
        @(negedge clk);
        checkOutput("full_ready", 32'(req_ready), 32'd0);
        checkOutput("full_overflow", 32'(overflow), 32'd1);
        checkOutput("full_count", 32'(count), 32'(DEPTH));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        pulseFinish();
        @(negedge clk);
        checkOutput("fin_done", 32'(done), 32'd1);
        checkOutput("fin_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Randomized traffic including resets, restarts and finishes with writes in flight
        for (int n = 0; n < 4000; n++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            start     = ($urandom_range(0, 11) == 0);
            finish    = ($urandom_range(0, 14) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_kind  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            req_rd    = 5'($urandom);
            req_rs1   = 5'($urandom);
            req_rs2   = 5'($urandom);
            if ($urandom_range(0, 1) == 0) immv = int'($urandom_range(0, 63)) - 32;
            else                           immv = int'($urandom_range(0, 8191)) - 4096;
            req_imm = 13'(immv);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1; start = 1'b0; finish = 1'b0; req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
